// File: rtl/ifetch_prefetch_pkg.sv
// Shared fetch constants: instruction size, default reset PC, PC increment.
package ifetch_prefetch_pkg;

    localparam int unsigned INSN_BYTES       = 4;
    localparam int unsigned PC_INC           = INSN_BYTES;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Fetch-stage bus bundle: imem request/response, redirect and decode channels.
interface ifetch_prefetch_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [XLEN-1:0]   imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [XLEN-1:0]   inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready,
        input  fetch_fault
    );
endinterface

// File: rtl/ifetch_prefetch_buffer.sv
// Reservation FIFO: an entry is claimed when a request is accepted and
// filled in order when its response returns; only filled heads are exposed.
module ifetch_prefetch_buffer #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reserve_i,
    input  logic [ADDR_W-1:0]      reserve_pc_i,
    input  logic                   fill_i,
    input  logic [XLEN-1:0]        fill_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] unfilled_o,
    output logic                   head_valid_o,
    output logic [XLEN-1:0]        head_data_o,
    output logic [ADDR_W-1:0]      head_pc_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CNT_W-1:0]  count_q, count_d, unfilled_q, unfilled_d;
    logic [DEPTH-1:0]  filled_q, filled_d;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        unfilled_d = unfilled_q;
        filled_d   = filled_q;
        if (flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            count_d    = '0;
            unfilled_d = '0;
            filled_d   = '0;
        end else begin
            // Fill always targets a non-head slot when a pop happens, so the two never collide.
            if (fill_i) begin
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + PTR_W'(1);
            end
            if (pop_i) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PTR_W'(1);
            end
            if (reserve_i) begin
                tail_d = tail_q + PTR_W'(1);
            end
            count_d    = count_q + CNT_W'(reserve_i) - CNT_W'(pop_i);
            unfilled_d = unfilled_q + CNT_W'(reserve_i) - CNT_W'(fill_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
            filled_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            unfilled_q <= unfilled_d;
            filled_q   <= filled_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reserve_i && !flush_i) pc_mem[tail_q] <= reserve_pc_i;
        if (fill_i && !flush_i)    data_mem[fill_q] <= fill_data_i;
    end

    assign count_o      = count_q;
    assign unfilled_o   = unfilled_q;
    assign head_valid_o = filled_q[head_q];
    assign head_data_o  = head_valid_o ? data_mem[head_q] : '0;
    assign head_pc_o    = head_valid_o ? pc_mem[head_q] : '0;

endmodule

// File: rtl/ifetch_prefetch.sv
// Fetch stage: PC, in-order imem requests, prefetch buffer, redirect flush.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (trap on misaligned redirect target).
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input logic               clk,
    input logic               rst,
    ifetch_prefetch_if.master fetch_io
);
    localparam int             CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d, redirect_tgt;
    logic [CNT_W-1:0]  discard_q, discard_d, count, unfilled;
    logic [CNT_W:0]    occupancy;
    logic              run_q, fault_q, fault_d;
    logic              req_valid, accept, fill, pop, head_valid;

    // Stale in-flight responses still occupy memory slots, so they count against capacity.
    assign occupancy = {1'b0, count} + {1'b0, discard_q};
    assign req_valid = run_q & (occupancy < DEPTH_C) & ~fetch_io.redirect_valid & ~fault_q;
    assign accept    = req_valid & fetch_io.imem_req_ready;
    assign fill      = fetch_io.imem_rsp_valid & (discard_q == '0) & ~fetch_io.redirect_valid;
    assign pop       = head_valid & fetch_io.inst_ready & ~fetch_io.redirect_valid;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign redirect_tgt = fetch_io.redirect_pc;
    assign fault_d      = fetch_io.redirect_valid ? misaligned(fetch_io.redirect_pc[1:0]) : fault_q;
`else
    assign redirect_tgt = fetch_io.redirect_pc & ~ADDR_W'(INSN_BYTES - 1);
    assign fault_d      = 1'b0;
`endif

    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        if (fetch_io.redirect_valid) begin
            pc_d      = redirect_tgt;
            discard_d = discard_q + unfilled - CNT_W'(fetch_io.imem_rsp_valid);
        end else begin
            if (accept) pc_d = pc_q + ADDR_W'(PC_INC);
            if (fetch_io.imem_rsp_valid && discard_q != '0) discard_d = discard_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
            run_q     <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
            run_q     <= 1'b1;
            fault_q   <= fault_d;
        end
    end

    ifetch_prefetch_buffer #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_buffer (
        .clk          (clk),
        .rst          (rst),
        .reserve_i    (accept),
        .reserve_pc_i (pc_q),
        .fill_i       (fill),
        .fill_data_i  (fetch_io.imem_rsp_data),
        .pop_i        (pop),
        .flush_i      (fetch_io.redirect_valid),
        .count_o      (count),
        .unfilled_o   (unfilled),
        .head_valid_o (head_valid),
        .head_data_o  (fetch_io.inst_data),
        .head_pc_o    (fetch_io.inst_pc)
    );

    assign fetch_io.imem_req_valid = req_valid;
    assign fetch_io.imem_req_addr  = pc_q;
    assign fetch_io.inst_valid     = head_valid;
    assign fetch_io.fetch_fault    = fault_q;

`ifndef SYNTHESIS
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        fetch_io.imem_rsp_valid |-> (discard_q != '0 || unfilled != '0));
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: queue-level reference model, randomized memory and decode.
module tb_ifetch_prefetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_prefetch_if #(.XLEN(32), .ADDR_W(32)) bus ();

    ifetch_prefetch #(
        .XLEN(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_io (bus)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit filled; } ment_t;

    mreq_t       memq[$];
    ment_t       mq[$];
    int          m_disc;
    bit          m_run, fault_m;
    logic [31:0] pc_m, stream_pc;

    int unsigned rdy_pct = 100, ir_pct = 100, lat_min = 1, lat_max = 1;
    bit          redir_req;
    logic [31:0] redir_pc_req;
    int          cyc, chks, errs, acc_cnt;
    logic [31:0] pops[$], pop_data[$];
    int          pop_cyc[$];
    logic        last_rv, last_ff;
    logic [31:0] last_ra;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        redir_req = 1'b0;
        memq.delete();
        mq.delete();
        m_disc = 0; m_run = 1'b0; fault_m = 1'b0; pc_m = '0; stream_pc = '0;
        repeat (3) begin
            #1;
            chk("rst_req_valid",  32'(bus.imem_req_valid), 32'h0);
            chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
            chk("rst_fault",      32'(bus.fetch_fault), 32'h0);
            chk("rst_inst_data",  bus.inst_data, 32'h0);
            chk("rst_inst_pc",    bus.inst_pc, 32'h0);
            @(posedge clk); cyc++; @(negedge clk);
        end
        rst = 1'b0;
        pops.delete(); pop_data.delete(); pop_cyc.delete();
        acc_cnt = 0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redir_req    = 1'b1;
        redir_pc_req = pc;
    endtask

    // One clock: drive at negedge, sample/check 1ns later, advance model, wait next negedge.
    task automatic step();
        logic        rv, rr, sv, iv, ir, rd, ff, exp_rv, exp_iv;
        logic [31:0] ra, rpc, ipc, idata;
        int          fi, unf;
        bus.imem_req_ready = ($urandom_range(1, 100) <= rdy_pct);
        bus.inst_ready     = ($urandom_range(1, 100) <= ir_pct);
        bus.redirect_valid = redir_req;
        bus.redirect_pc    = redir_pc_req;
        redir_req = 1'b0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memq[0].addr ^ MAGIC;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom();
        end
        #1;
        rv = bus.imem_req_valid; rr = bus.imem_req_ready; ra = bus.imem_req_addr;
        sv = bus.imem_rsp_valid; rd = bus.redirect_valid; rpc = bus.redirect_pc;
        iv = bus.inst_valid; ir = bus.inst_ready; ipc = bus.inst_pc; idata = bus.inst_data;
        ff = bus.fetch_fault;

        exp_rv = m_run && (mq.size() + m_disc < DEPTH) && !rd && !fault_m;
        exp_iv = (mq.size() > 0) && mq[0].filled;
        chk("req_valid", 32'(rv), 32'(exp_rv));
        if (exp_rv) chk("req_addr", ra, pc_m);
        chk("inst_valid", 32'(iv), 32'(exp_iv));
        if (exp_iv) begin
            chk("inst_pc", ipc, mq[0].pc);
            chk("inst_data", idata, mq[0].pc ^ MAGIC);
        end
        chk("fetch_fault", 32'(ff), 32'(fault_m));
        last_rv = rv; last_ra = ra; last_ff = ff;

        if (rd) begin
            unf = 0;
            foreach (mq[k]) if (!mq[k].filled) unf++;
            m_disc = m_disc + unf - (sv ? 1 : 0);
            mq.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_m = (rpc[1:0] != 2'b00);
            pc_m    = rpc;
`else
            pc_m    = rpc & 32'hFFFF_FFFC;
`endif
            stream_pc = pc_m;
        end else begin
            if (sv) begin
                if (m_disc > 0) m_disc--;
                else begin
                    fi = -1;
                    for (int k = 0; k < mq.size(); k++) if (!mq[k].filled) begin fi = k; break; end
                    if (fi < 0) chk("rsp_has_slot", 32'h0, 32'h1);
                    else mq[fi].filled = 1'b1;
                end
            end
            if (exp_iv && ir) begin
                chk("pop_order", ipc, stream_pc);
                stream_pc += 32'd4;
                void'(mq.pop_front());
            end
            if (exp_rv && rr) begin
                mq.push_back('{pc: pc_m, filled: 1'b0});
                pc_m += 32'd4;
            end
            if (iv && ir) begin
                pops.push_back(ipc); pop_data.push_back(idata); pop_cyc.push_back(cyc);
            end
        end
        if (sv) void'(memq.pop_front());
        if (rv && rr) begin
            memq.push_back('{addr: ra, due: cyc + int'($urandom_range(lat_min, lat_max))});
            acc_cnt++;
        end
        m_run = 1'b1;
        @(posedge clk); cyc++; @(negedge clk);
    endtask

    initial begin
        cyc = 0; chks = 0; errs = 0;
        @(negedge clk);

        // Reset, then first request of RESET_PC one cycle after release
        rdy_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        step(); step();
        chk("t1_req_valid", 32'(last_rv), 32'h1);
        chk("t1_req_addr", last_ra, 32'h0);

        // Back-to-back streaming with single-cycle memory
        do_reset();
        repeat (14) step();
        chk("t2_pop_count", 32'(pops.size() >= 8), 32'h1);
        for (int i = 0; i < 8 && i < pops.size(); i++) begin
            chk("t2_pc", pops[i], 32'(i * 4));
            chk("t2_data", pop_data[i], 32'(i * 4) ^ MAGIC);
            if (i > 0) chk("t2_b2b", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'h1);
        end
        if (pop_data.size() > 1) chk("t2_data_lit", pop_data[1], 32'hA5A5_A5A1);

        // Decode stalled: buffer fills to DEPTH then drains in order
        do_reset();
        ir_pct = 0;
        repeat (10) step();
        chk("t3_accepts", 32'(acc_cnt), 32'd4);
        chk("t3_req_stop", 32'(last_rv), 32'h0);
        ir_pct = 100;
        repeat (6) step();
        chk("t3_pop_count", 32'(pops.size() >= 4), 32'h1);
        for (int i = 0; i < 4 && i < pops.size(); i++) chk("t3_pc", pops[i], 32'(i * 4));

        // Redirect with two fetches in flight: stale data dropped
        do_reset();
        lat_min = 3; lat_max = 3;
        repeat (3) step();
        chk("t4_inflight", 32'(acc_cnt), 32'd2);
        redirect(32'h100);
        step();
        pops.delete();
        step();
        chk("t4_req_valid", 32'(last_rv), 32'h1);
        chk("t4_req_addr", last_ra, 32'h100);
        repeat (10) step();
        chk("t4_pop_count", 32'(pops.size() >= 1), 32'h1);
        if (pops.size() > 0) chk("t4_first_pc", pops[0], 32'h100);

        // Memory back-pressure: request held with stable address
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (3) step();
        rdy_pct = 0;
        repeat (5) begin
            step();
            chk("t5_req_valid", 32'(last_rv), 32'h1);
            chk("t5_req_addr", last_ra, 32'h8);
        end
        rdy_pct = 100;

        // Misaligned redirect target
        do_reset();
        repeat (4) step();
        redirect(32'h102);
        step(); step();
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("t6_fault", 32'(last_ff), 32'h1);
        chk("t6_no_req", 32'(last_rv), 32'h0);
        acc_cnt = 0;
        repeat (4) step();
        chk("t6_no_accepts", 32'(acc_cnt), 32'h0);
        chk("t6_fault_sticky", 32'(last_ff), 32'h1);
`else
        chk("t6_fault_tied", 32'(last_ff), 32'h0);
        chk("t6_forced_align", last_ra, 32'h100);
        repeat (4) step();
`endif
        redirect(32'h200);
        step(); step();
        chk("t6_fault_clear", 32'(last_ff), 32'h0);
        chk("t6_req_valid", 32'(last_rv), 32'h1);
        chk("t6_req_addr", last_ra, 32'h200);

        // PC wrap at top of address space
        do_reset();
        repeat (2) step();
        redirect(32'hFFFF_FFF8);
        step();
        pops.delete();
        repeat (10) step();
        chk("t7_pop_count", 32'(pops.size() >= 3), 32'h1);
        if (pops.size() >= 3) begin
            chk("t7_pc0", pops[0], 32'hFFFF_FFF8);
            chk("t7_pc1", pops[1], 32'hFFFF_FFFC);
            chk("t7_pc2", pops[2], 32'h0000_0000);
        end

        // Randomized traffic with a reset in the middle
        do_reset();
        rdy_pct = 70; ir_pct = 60; lat_min = 1; lat_max = 4;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            if ($urandom_range(0, 99) < 4) begin
                redir_pc_req = $urandom();
                if ($urandom_range(0, 3) != 0) redir_pc_req[1:0] = 2'b00;
                redir_req = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", chks, errs);
        $finish;
    end

endmodule
